mxu_sched: RTL and testbench



---
 rtl/mxu_pkg.sv | 24 ++
 rtl/mxu_valid_skew.sv | 44 ++++
 rtl/mxu_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_mxu_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mxu_pkg.sv
// mxu_pkg -- shared definitions for the MXU sequencing controller.
//   state_e          : controller states (IDLE, LOAD_W, STREAM, DRAIN, DONE)
//   *_DEF            : default array dimension, pipeline latency, counter width
//   addr_w()         : address width helper (never narrower than one bit)
package mxu_pkg;

  localparam int ARRAY_DIM_DEF  = 8;
  localparam int PIPE_LAT_DEF   = 16;
  localparam int VEC_CNT_BW_DEF = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Width needed to address n entries; a one-entry space still gets one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxu_valid_skew.sv
// mxu_valid_skew -- valid delay line for the MXU.
// Shifts the registered activation-read enable once per cycle. Tap j carries
// the enable delayed j+1 cycles, so the low ARRAY_DIM taps are the per-row
// skewed valids and the last tap is the result-write strobe.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of every pending valid (job cancel)
//   vld_in    : registered activation read enable
//   row_vld   : bit r = vld_in delayed r+1 cycles
//   wr_pre    : vld_in delayed PIPE_LAT-1 cycles (write strobe one cycle early)
//   wr_vld    : vld_in delayed PIPE_LAT cycles (result write strobe)
module mxu_valid_skew
  import mxu_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 vld_in,
  output logic [ARRAY_DIM-1:0] row_vld,
  output logic                 wr_pre,
  output logic                 wr_vld
);

  logic [PIPE_LAT-1:0] sr_r;

  // Shift register holding the in-flight vector valids.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_r <= '0;
    end else if (clr) begin
      sr_r <= '0;
    end else begin
      sr_r <= {sr_r[PIPE_LAT-2:0], vld_in};
    end
  end

  assign row_vld = sr_r[ARRAY_DIM-1:0];
  assign wr_pre  = sr_r[PIPE_LAT-2];
  assign wr_vld  = sr_r[PIPE_LAT-1];

endmodule

// File: rtl/mxu_sched.sv
// mxu_sched -- sequencing controller for the weight-stationary MXU.
// One start loads ARRAY_DIM weight rows, streams num_vecs activation vectors,
// tracks them through the array pipeline into the result buffer and pulses
// done. All outputs are registered, so each appears one cycle after the state
// that produces it.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   start, abort         : job request (IDLE only) / synchronous cancel
//   num_vecs             : vector count, latched on accepted start
//   busy, done           : job activity / one-cycle completion pulse
//   w_rd_en, w_addr      : weight buffer read
//   we_rl                : one-hot weight reload strobe per array row
//   din_rd_en, din_addr  : activation buffer read
//   row_vld              : per-row skewed input valids
//   out_wr_en, out_addr  : result buffer write
//   perf_cycles          : busy-cycle counter (only with MXU_SCHED_PERF_EN)
// Build option: define MXU_SCHED_PERF_EN to add perf_cycles.
module mxu_sched
  import mxu_pkg::*;
#(
  parameter int ARRAY_DIM  = ARRAY_DIM_DEF,
  parameter int VEC_CNT_BW = VEC_CNT_BW_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [VEC_CNT_BW-1:0]         num_vecs,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [addr_w(ARRAY_DIM)-1:0]  w_addr,
  output logic [ARRAY_DIM-1:0]          we_rl,
  output logic                          din_rd_en,
  output logic [VEC_CNT_BW-1:0]         din_addr,
  output logic [ARRAY_DIM-1:0]          row_vld,
  output logic                          out_wr_en,
  output logic [VEC_CNT_BW-1:0]         out_addr
`ifdef MXU_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int WA_W = addr_w(ARRAY_DIM);
  localparam int LC_W = $clog2(ARRAY_DIM + 1);

  state_e                 state_r, state_s;
  logic [VEC_CNT_BW-1:0]  nv_r, scnt_r, ocnt_r;
  logic [LC_W-1:0]        lcnt_r;
  logic                   accept_s, kill_s, wr_pre_s;

  logic                   busy_s, done_s, w_rd_en_s, din_rd_en_s;
  logic [WA_W-1:0]        w_addr_s;
  logic [ARRAY_DIM-1:0]   we_rl_s;
  logic [VEC_CNT_BW-1:0]  din_addr_s;

  logic                   busy_r, done_r, w_rd_en_r, din_rd_en_r;
  logic [WA_W-1:0]        w_addr_r;
  logic [ARRAY_DIM-1:0]   we_rl_r;
  logic [VEC_CNT_BW-1:0]  din_addr_r, out_addr_r;

  // abort wins over start, so a start with abort in IDLE is dropped too.
  assign accept_s = (state_r == IDLE) && start && !abort;
  assign kill_s   = (state_r != IDLE) && abort;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. DRAIN leaves as the final write is issued (one cycle
  // ahead of out_wr_en) so that DONE lines up right after the last write.
  always_comb begin
    state_s = state_r;
    if (kill_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = accept_s ? LOAD_W : IDLE;
        LOAD_W:  if (lcnt_r == LC_W'(ARRAY_DIM)) begin
                   state_s = (nv_r == '0) ? DONE : STREAM;
                 end else begin
                   state_s = LOAD_W;
                 end
        STREAM:  state_s = (scnt_r == nv_r - VEC_CNT_BW'(1)) ? DRAIN : STREAM;
        DRAIN:   state_s = (wr_pre_s && (ocnt_r + VEC_CNT_BW'(1) == nv_r)) ? DONE : DRAIN;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Job counters: latched length, weight row, streamed and issued vectors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nv_r   <= '0;
      lcnt_r <= '0;
      scnt_r <= '0;
      ocnt_r <= '0;
    end else if (accept_s) begin
      nv_r   <= num_vecs;
      lcnt_r <= '0;
      scnt_r <= '0;
      ocnt_r <= '0;
    end else if (kill_s) begin
      lcnt_r <= '0;
      scnt_r <= '0;
      ocnt_r <= '0;
    end else begin
      if (state_r == LOAD_W) lcnt_r <= lcnt_r + LC_W'(1);
      if (state_r == STREAM) scnt_r <= scnt_r + VEC_CNT_BW'(1);
      if (wr_pre_s)          ocnt_r <= ocnt_r + VEC_CNT_BW'(1);
    end
  end

  // Output decode. LOAD_W cycle i reads weight row i; the row arrives one
  // cycle later, which is when its reload strobe fires.
  always_comb begin
    busy_s      = 1'b0;
    done_s      = 1'b0;
    w_rd_en_s   = 1'b0;
    w_addr_s    = '0;
    we_rl_s     = '0;
    din_rd_en_s = 1'b0;
    din_addr_s  = '0;
    if (kill_s) begin
      busy_s = 1'b0;
    end else begin
      busy_s = (state_r != IDLE);
      done_s = (state_r == DONE);
      case (state_r)
        LOAD_W: begin
          w_rd_en_s = (lcnt_r < LC_W'(ARRAY_DIM));
          w_addr_s  = lcnt_r[WA_W-1:0];
          if (lcnt_r != '0) begin
            we_rl_s = ARRAY_DIM'(1) << (lcnt_r - LC_W'(1));
          end else begin
            we_rl_s = '0;
          end
        end
        STREAM: begin
          din_rd_en_s = 1'b1;
          din_addr_s  = scnt_r;
        end
        default: begin
          w_rd_en_s = 1'b0;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      w_rd_en_r   <= 1'b0;
      w_addr_r    <= '0;
      we_rl_r     <= '0;
      din_rd_en_r <= 1'b0;
      din_addr_r  <= '0;
      out_addr_r  <= '0;
    end else begin
      busy_r      <= busy_s;
      done_r      <= done_s;
      w_rd_en_r   <= w_rd_en_s;
      w_addr_r    <= w_addr_s;
      we_rl_r     <= we_rl_s;
      din_rd_en_r <= din_rd_en_s;
      din_addr_r  <= din_addr_s;
      out_addr_r  <= ocnt_r;
    end
  end

  mxu_valid_skew #(
    .ARRAY_DIM (ARRAY_DIM),
    .PIPE_LAT  (PIPE_LAT)
  ) u_skew (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (kill_s),
    .vld_in  (din_rd_en_r),
    .row_vld (row_vld),
    .wr_pre  (wr_pre_s),
    .wr_vld  (out_wr_en)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign w_rd_en   = w_rd_en_r;
  assign w_addr    = w_addr_r;
  assign we_rl     = we_rl_r;
  assign din_rd_en = din_rd_en_r;
  assign din_addr  = din_addr_r;
  assign out_addr  = out_addr_r;

`ifdef MXU_SCHED_PERF_EN
  logic [31:0] perf_r;

  // Busy-cycle counter: restarts on accept, holds after the job, saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_r <= 32'd0;
    end else if (accept_s) begin
      perf_r <= 32'd0;
    end else if ((state_r != IDLE) && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end
  end

  assign perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_mxu_sched.sv
module tb_mxu_sched;
  localparam int AD = 8;
  localparam int PL = 16;
  localparam int VB = 10;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic          clk, rstn, start, abort;
  logic [VB-1:0] num_vecs;
  logic          busy, done, w_rd_en, din_rd_en, out_wr_en;
  logic [2:0]    w_addr;
  logic [AD-1:0] we_rl, row_vld;
  logic [VB-1:0] din_addr, out_addr;
`ifdef MXU_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  mxu_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_vecs(num_vecs),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .we_rl(we_rl),
    .din_rd_en(din_rd_en), .din_addr(din_addr), .row_vld(row_vld),
    .out_wr_en(out_wr_en), .out_addr(out_addr)
`ifdef MXU_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one job described by accept edge, length and abort edge.
  bit m_valid = 1'b0;
  int m_a, m_nv, m_end, m_kill;

  typedef struct {
    int nv;
    int done_rel;
    int writes;
    int first_wr;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit din_at(int rel);
    return (rel >= AD + 2) && (rel < AD + 2 + m_nv);
  endfunction

  // Apply the job rules at clock edge e using the inputs sampled there.
  task automatic model_edge(input int e);
    bit idle;
    if (!rstn) begin
      m_valid = 1'b0;
    end else begin
      idle = !m_valid || (e - 1 >= m_a + m_end) || (e - 1 >= m_kill);
      if (idle) begin
        if (start && !abort) begin
          m_valid = 1'b1;
          m_a     = e;
          m_nv    = int'(num_vecs);
          m_end   = (m_nv == 0) ? AD + 2 : AD + 2 + m_nv + PL;
          m_kill  = NEVER;
        end
      end else if (abort) begin
        m_kill = e;
      end
    end
  endtask

  // Compare every output seen after edge e against the model.
  task automatic check_cycle(input int e);
    int rel, ewa, edina, eoa, stop, pv;
    bit care;
    logic eb, ed, ew, edin, eo;
    logic [AD-1:0] erl, erv;
    care = 1'b1; eb = 0; ed = 0; ew = 0; edin = 0; eo = 0;
    ewa = 0; edina = 0; eoa = 0; erl = '0; erv = '0; pv = 0;
    if (m_valid) begin
      stop = (m_a + m_end < m_kill) ? m_a + m_end : m_kill;
      pv = ((e < stop) ? e : stop) - m_a;
      if (e == m_kill) begin
        care = 1'b0;
      end else if (e < m_kill) begin
        rel   = e - m_a;
        eb    = (rel >= 1) && (rel <= m_end);
        ed    = (rel == m_end);
        ew    = (rel >= 1) && (rel <= AD);
        ewa   = rel - 1;
        if (rel >= 2 && rel <= AD + 1) erl = AD'(1) << (rel - 2);
        edin  = din_at(rel);
        edina = rel - (AD + 2);
        for (int r = 0; r < AD; r++) erv[r] = din_at(rel - 1 - r);
        eo    = din_at(rel - PL);
        eoa   = rel - PL - (AD + 2);
      end
    end
    if (care) begin
      chk("busy_done", {busy, done}, {eb, ed});
      chk("wbuf", w_rd_en ? 64'h10000 + w_addr : 64'd0, ew ? 64'h10000 + ewa : 64'd0);
      chk("we_rl", we_rl, erl);
      chk("din", din_rd_en ? 64'h10000 + din_addr : 64'd0, edin ? 64'h10000 + edina : 64'd0);
      chk("row_vld", row_vld, erv);
      chk("out", out_wr_en ? 64'h10000 + out_addr : 64'd0, eo ? 64'h10000 + eoa : 64'd0);
    end
`ifdef MXU_SCHED_PERF_EN
    chk("perf", perf_cycles, pv);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    check_cycle(cyc);
  endtask

  // Run one job to completion and measure it relative to its accept edge.
  task automatic run_job(input int nv, output int dn, output int wr, output int first);
    int a;
    start = 1'b1; num_vecs = VB'(nv);
    step();
    a = cyc; start = 1'b0;
    dn = -1; wr = 0; first = -1;
    for (int i = 0; i < 200 && dn < 0; i++) begin
      step();
      if (out_wr_en) begin
        wr++;
        if (first < 0) first = cyc - a;
      end
      if (done) dn = cyc - a;
    end
    step();
  endtask

  initial begin
    int dn, wr, first, a, d1, d2, b31, ndone;

    tbl[0] = '{nv: 4,  done_rel: 30, writes: 4,  first_wr: 26};
    tbl[1] = '{nv: 0,  done_rel: 10, writes: 0,  first_wr: -1};
    tbl[2] = '{nv: 1,  done_rel: 27, writes: 1,  first_wr: 26};
    tbl[3] = '{nv: 7,  done_rel: 33, writes: 7,  first_wr: 26};
    tbl[4] = '{nv: 20, done_rel: 46, writes: 20, first_wr: 26};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; num_vecs = '0;
    #12;
    chk("reset_ctl", {busy, done, w_rd_en, din_rd_en, out_wr_en}, 5'd0);
    chk("reset_vec", {we_rl, row_vld}, 16'd0);
    chk("reset_addr", {w_addr, din_addr, out_addr}, 23'd0);
    rstn = 1'b1;
    step();

    // Table-driven jobs.
    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].nv, dn, wr, first);
      chk("tbl_done_rel", dn, tbl[i].done_rel);
      chk("tbl_writes", wr, tbl[i].writes);
      chk("tbl_first_wr", first, tbl[i].first_wr);
    end

    // Abort in cycle 12 of a 4-vector job, then a clean job.
    start = 1'b1; num_vecs = VB'(4);
    step();
    a = cyc; start = 1'b0;
    while (cyc < a + 11) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("abort_idle", busy, 1'b0);
    wr = 0; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_wr_en) wr++;
      if (done) ndone++;
    end
    chk("abort_no_wr", wr, 0);
    chk("abort_no_done", ndone, 0);
    run_job(4, dn, wr, first);
    chk("post_abort_done", dn, 30);
    chk("post_abort_wr", wr, 4);

    // start held high across two jobs.
    start = 1'b1; num_vecs = VB'(4);
    step();
    a = cyc; d1 = -1; d2 = -1; b31 = -1;
    while (cyc < a + 61) begin
      step();
      if (cyc == a + 31) b31 = busy;
      if (done) begin
        if (d1 < 0) d1 = cyc - a;
        else d2 = cyc - a;
      end
    end
    start = 1'b0;
    chk("held_done1", d1, 30);
    chk("held_gap", b31, 0);
    chk("held_done2", d2, 61);
    step();

    // Asynchronous reset in the middle of a job.
    start = 1'b1; num_vecs = VB'(4);
    step();
    a = cyc; start = 1'b0;
    while (cyc < a + 20) step();
    #2 rstn = 1'b0;
    #1;
    m_valid = 1'b0;
    chk("rst_async", {busy, done, w_rd_en, din_rd_en, out_wr_en, we_rl, row_vld}, 21'd0);
    step();
    step();
    #2 rstn = 1'b1;
    step();
    chk("rst_release_busy", busy, 1'b0);
    run_job(3, dn, wr, first);
    chk("post_rst_done", dn, 29);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      num_vecs = VB'($urandom_range(0, 24));
      step();
    end
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 60; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
